// File: rtl/request_queue_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// request_queue_arb : N-requester first-come-first-served arbiter with a
//                     registered one-hot grant and optional forced rotation.
// Revision 1.0
// ---------------------------------------------------------------------------
module request_queue_arb #(
   parameter int N        = 4,
   parameter int TIE_MODE = 0,
   parameter int MAX_HOLD = 0,
   parameter int IDX_W    = $clog2(N)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N-1:0]     req_i,
   output logic [N-1:0]     grant_o,
   output logic             grant_valid_o,
   output logic [IDX_W-1:0] grant_id_o,
   output logic [IDX_W:0]   queue_count_o
);

   localparam int               CNT_W    = IDX_W + 1;
   localparam logic [7:0]       HOLD_SAT = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD);
   localparam logic [N-1:0]     ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N - 1);

   logic [IDX_W-1:0] queue_q [N];
   logic [IDX_W-1:0] queue_d [N];
   logic [CNT_W-1:0] count_q, count_d;
   logic [N-1:0]     grant_q, grant_d;
   logic             valid_q, valid_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [7:0]       hold_q, hold_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   logic [N-1:0]     queued;
   logic [N-1:0]     arrive;
   logic [IDX_W-1:0] idx;
   logic             owner_rel;
   logic             preempt;
   logic             pick;
   int               tie_base;

   always_comb begin
      queued    = '0;
      arrive    = '0;
      idx       = '0;
      owner_rel = 1'b0;
      preempt   = 1'b0;
      pick      = 1'b0;
      tie_base  = 0;
      count_d   = '0;
      for (int k = 0; k < N; k++) begin
         queue_d[k] = '0;
      end

      for (int k = 0; k < N; k++) begin
         if (CNT_W'(k) < count_q) begin
            queued[queue_q[k]] = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         arrive[i] = req_i[i] & ~queued[i] & ~(valid_q && (owner_q == IDX_W'(i)));
      end

      // Compact surviving entries to the front, keeping arrival order.
      for (int k = 0; k < N; k++) begin
         if ((CNT_W'(k) < count_q) && req_i[queue_q[k]]) begin
            queue_d[count_d[IDX_W-1:0]] = queue_q[k];
            count_d = count_d + 1'b1;
         end
      end

      tie_base = (TIE_MODE != 0) ? ((int'(ptr_q) + 1) % N) : 0;
      for (int k = 0; k < N; k++) begin
         idx = IDX_W'((tie_base + k) % N);
         if (arrive[idx]) begin
            queue_d[count_d[IDX_W-1:0]] = idx;
            count_d = count_d + 1'b1;
         end
      end

      owner_rel = valid_q & ~req_i[owner_q];
      preempt   = (MAX_HOLD != 0) && valid_q && req_i[owner_q] &&
                  (hold_q == HOLD_SAT) && (count_d != '0);
      // A preempted owner goes behind everyone, including this edge's arrivals.
      if (preempt) begin
         queue_d[count_d[IDX_W-1:0]] = owner_q;
         count_d = count_d + 1'b1;
      end

      pick    = ~valid_q | owner_rel | preempt;
      owner_d = owner_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      hold_d  = (valid_q && (hold_q != HOLD_SAT)) ? hold_q + 8'd1 : hold_q;

      if (pick) begin
         if (count_d != '0) begin
            owner_d = queue_d[0];
            ptr_d   = queue_d[0];
            valid_d = 1'b1;
            hold_d  = 8'd1;
            for (int k = 0; k < N - 1; k++) begin
               queue_d[k] = queue_d[k+1];
            end
            queue_d[N-1] = '0;
            count_d      = count_d - 1'b1;
         end else begin
            owner_d = '0;
            valid_d = 1'b0;
            hold_d  = 8'd0;
         end
      end

      grant_d = valid_d ? (ONE_HOT0 << owner_d) : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < N; k++) begin
            queue_q[k] <= '0;
         end
         count_q <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
         owner_q <= '0;
         hold_q  <= 8'd0;
         ptr_q   <= PTR_RST;
      end else begin
         for (int k = 0; k < N; k++) begin
            queue_q[k] <= queue_d[k];
         end
         count_q <= count_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         owner_q <= owner_d;
         hold_q  <= hold_d;
         ptr_q   <= ptr_d;
      end
   end

   assign grant_o       = grant_q;
   assign grant_valid_o = valid_q;
   assign grant_id_o    = owner_q;
   assign queue_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_request_queue_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_request_queue_arb : three arbiter configurations driven by one request
//                        vector and compared against a queue-based model.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_request_queue_arb;

   localparam int N  = 4;
   localparam int NI = 3;

   logic         clk_i  = 1'b0;
   logic         rst_ni = 1'b1;
   logic [N-1:0] req    = '0;

   logic [N-1:0] g   [NI];
   logic         v   [NI];
   logic [1:0]   gid [NI];
   logic [2:0]   qc  [NI];

   int checks = 0;
   int errors = 0;

   // model state per instance: waiting list, owner (-1 idle), hold, rr pointer
   int mq   [NI][$];
   int own  [NI];
   int hold [NI];
   int ptr  [NI];

   always #5 clk_i = ~clk_i;

   request_queue_arb #(.N(N), .TIE_MODE(0), .MAX_HOLD(0)) u_arb0 (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .grant_o(g[0]),
      .grant_valid_o(v[0]), .grant_id_o(gid[0]), .queue_count_o(qc[0]));
   request_queue_arb #(.N(N), .TIE_MODE(1), .MAX_HOLD(0)) u_arb1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .grant_o(g[1]),
      .grant_valid_o(v[1]), .grant_id_o(gid[1]), .queue_count_o(qc[1]));
   request_queue_arb #(.N(N), .TIE_MODE(1), .MAX_HOLD(4)) u_arb2 (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .grant_o(g[2]),
      .grant_valid_o(v[2]), .grant_id_o(gid[2]), .queue_count_o(qc[2]));

   function automatic int tie_of(input int m);
      return (m == 0) ? 0 : 1;
   endfunction

   function automatic int maxh_of(input int m);
      return (m == 2) ? 4 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < NI; m++) begin
         mq[m].delete();
         own[m]  = -1;
         hold[m] = 0;
         ptr[m]  = N - 1;
      end
   endtask

   task automatic model_step(input logic [N-1:0] r);
      for (int m = 0; m < NI; m++) begin
         int  s;
         int  i;
         bit  inq;
         bit  rel;
         bit  pre;
         for (int k = mq[m].size() - 1; k >= 0; k--) begin
            if (!r[mq[m][k]]) mq[m].delete(k);
         end
         s = (tie_of(m) != 0) ? ptr[m] + 1 : 0;
         for (int k = 0; k < N; k++) begin
            i   = (s + k) % N;
            inq = 1'b0;
            for (int j = 0; j < mq[m].size(); j++) begin
               if (mq[m][j] == i) inq = 1'b1;
            end
            if (r[i] && (i != own[m]) && !inq) mq[m].push_back(i);
         end
         rel = (own[m] >= 0) && !r[own[m]];
         pre = (maxh_of(m) > 0) && (own[m] >= 0) && r[own[m]] &&
               (hold[m] == maxh_of(m)) && (mq[m].size() > 0);
         if (pre) mq[m].push_back(own[m]);
         if ((own[m] < 0) || rel || pre) begin
            if (mq[m].size() > 0) begin
               own[m]  = mq[m].pop_front();
               hold[m] = 1;
               ptr[m]  = own[m];
            end else begin
               own[m]  = -1;
               hold[m] = 0;
            end
         end else begin
            hold[m]++;
            if ((maxh_of(m) > 0) && (hold[m] > maxh_of(m))) hold[m] = maxh_of(m);
         end
      end
   endtask

   task automatic compare_all();
      for (int m = 0; m < NI; m++) begin
         int eg;
         eg = (own[m] < 0) ? 0 : (1 << own[m]);
         chk($sformatf("grant[u%0d]", m), 32'(g[m]), 32'(eg));
         chk($sformatf("valid[u%0d]", m), 32'(v[m]), 32'(own[m] >= 0));
         chk($sformatf("id[u%0d]", m), 32'(gid[m]), 32'((own[m] < 0) ? 0 : own[m]));
         chk($sformatf("qcount[u%0d]", m), 32'(qc[m]), 32'(mq[m].size()));
      end
   endtask

   task automatic cycle(input logic [N-1:0] r);
      req = r;
      @(posedge clk_i);
      #1;
      model_step(r);
      compare_all();
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk_i);
      #1;
      compare_all();
      rst_ni = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int           cnt;
      logic [N-1:0] r;
      logic [N-1:0] flip;

      // all four requesting through reset release
      req = 4'b1111;
      #1;
      do_reset();
      cycle(4'b1111);
      chk("t1_first_grant", 32'(g[0]), 32'h1);
      chk("t1_first_id", 32'(gid[0]), 32'd0);
      chk("t1_first_qc", 32'(qc[0]), 32'd3);
      cycle(4'b1110);
      chk("t1_second_grant", 32'(g[0]), 32'h2);
      chk("t1_second_qc", 32'(qc[0]), 32'd2);
      cycle(4'b1100);
      chk("t1_third_grant", 32'(g[0]), 32'h4);
      cycle(4'b1000);
      chk("t1_fourth_grant", 32'(g[0]), 32'h8);
      chk("t1_fourth_qc", 32'(qc[0]), 32'd0);
      cycle(4'b0000);

      // arrival order beats index order
      do_reset();
      cycle(4'b0010);
      cycle(4'b0110);
      cycle(4'b0110);
      cycle(4'b0111);
      cycle(4'b0111);
      cycle(4'b1111);
      chk("t2_qc3", 32'(qc[0]), 32'd3);
      cycle(4'b1101);
      chk("t2_owner2", 32'(g[0]), 32'h4);
      cycle(4'b1001);
      chk("t2_owner0", 32'(g[0]), 32'h1);
      cycle(4'b1000);
      chk("t2_owner3", 32'(g[0]), 32'h8);
      chk("t2_qc0", 32'(qc[0]), 32'd0);
      cycle(4'b0000);

      // same-edge tie-break after owner 2
      do_reset();
      cycle(4'b0100);
      cycle(4'b1011);
      chk("t3_fixed_first", 32'(g[0]), 32'h1);
      chk("t3_rr_first", 32'(g[1]), 32'h8);
      cycle(4'b0011);
      cycle(4'b0010);
      cycle(4'b0000);

      // withdrawal from the middle of the queue
      do_reset();
      cycle(4'b0010);
      cycle(4'b0110);
      cycle(4'b0111);
      cycle(4'b1111);
      cycle(4'b1110);
      chk("t4_qc_after_withdraw", 32'(qc[0]), 32'd2);
      cycle(4'b1100);
      chk("t4_owner2", 32'(g[0]), 32'h4);
      cycle(4'b1000);
      chk("t4_owner3", 32'(g[0]), 32'h8);
      cycle(4'b0000);

      // forced rotation after four held cycles
      do_reset();
      cycle(4'b0001);
      cnt = (g[2] == 4'b0001) ? 1 : 0;
      for (int k = 1; k < 8; k++) begin
         cycle(4'b0011);
         if (g[2] == 4'b0001) cnt++;
         if (k == 4) begin
            chk("t5_rotated_grant", 32'(g[2]), 32'h2);
            chk("t5_rotated_qc", 32'(qc[2]), 32'd1);
         end
      end
      chk("t5_hold_cycles", 32'(cnt), 32'd4);
      cycle(4'b0000);
      do_reset();
      cnt = 0;
      for (int k = 0; k < 25; k++) begin
         cycle(4'b0001);
         if (g[2] == 4'b0001) cnt++;
      end
      chk("t5_no_competitor", 32'(cnt), 32'd25);

      // asynchronous reset between edges
      do_reset();
      cycle(4'b0100);
      cycle(4'b1101);
      chk("t6_qc_before", 32'(qc[0]), 32'd2);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("t6_async_grant", 32'(g[0]), 32'h0);
      chk("t6_async_valid", 32'(v[0]), 32'h0);
      chk("t6_async_qc", 32'(qc[0]), 32'h0);
      model_reset();
      compare_all();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      cycle(4'b1101);
      chk("t6_restart_fixed", 32'(g[0]), 32'h1);
      chk("t6_restart_rr", 32'(g[1]), 32'h1);

      // randomized traffic with occasional resets
      r = '0;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            flip = '0;
            for (int b = 0; b < N; b++) begin
               if ($urandom_range(0, 3) == 0) flip[b] = 1'b1;
            end
            r = r ^ flip;
            cycle(r);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
